commit_monitor: RTL and testbench

COMMIT_MONITOR -- requirements
Module: commit_monitor

---
 rtl/commit_monitor.sv | 138 +++++++++++++
 tb/tb_commit_monitor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/commit_monitor.sv
// rtl/commit_monitor.sv - ROB commit progress monitor
// Counts retirements and cycles, emits periodic progress reports, flags hangs and bad commit masks.
module commit_monitor #(
  parameter int COMMIT_WIDTH    = 6,
  parameter int STUCK_LIMIT     = 5000,
  parameter int REPORT_INTERVAL = 10000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [COMMIT_WIDTH-1:0] commit_valid,
  input  logic                    commit_is_walk,
  output logic [63:0]             instr_cnt,
  output logic [63:0]             cycle_cnt,
  output logic                    report_valid,
  output logic [63:0]             report_cycle,
  output logic [63:0]             report_instr,
  output logic [63:0]             report_window_instr,
  output logic                    hang,
  output logic [63:0]             hang_cycle,
  output logic                    protocol_err
);

  localparam int TW = $clog2(STUCK_LIMIT + 2);
  localparam int IW = $clog2(REPORT_INTERVAL + 1);
  localparam int CW = $clog2(COMMIT_WIDTH + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(STUCK_LIMIT + 1);
  localparam logic [IW-1:0] INTV_LAST = IW'(REPORT_INTERVAL - 1);

  logic [63:0]   cycle_cnt_q, cycle_cnt_d;
  logic [63:0]   instr_cnt_q, instr_cnt_d;
  logic [TW-1:0] stuck_q, stuck_d;
  logic [IW-1:0] intv_q, intv_d;
  logic          report_valid_q, report_valid_d;
  logic [63:0]   report_cycle_q, report_cycle_d;
  logic [63:0]   report_instr_q, report_instr_d;
  logic [63:0]   report_win_q, report_win_d;
  logic          hang_q, hang_d;
  logic [63:0]   hang_cycle_q, hang_cycle_d;
  logic          perr_q, perr_d;

  logic          retire;
  logic [CW-1:0] n;
  logic          gap;
  logic          is_report;

  always_comb begin
    retire = !commit_is_walk;

    n   = '0;
    gap = 1'b0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      n = n + CW'(commit_valid[i]);
    end
    for (int i = 1; i < COMMIT_WIDTH; i++) begin
      gap = gap | (commit_valid[i] & ~commit_valid[i-1]);
    end

    cycle_cnt_d = cycle_cnt_q + 64'd1;
    instr_cnt_d = instr_cnt_q + (retire ? 64'(n) : 64'd0);

    // Only a retirement from the oldest slot proves forward progress; walks never do.
    if (retire && commit_valid[0]) begin
      stuck_d = '0;
    end else if (stuck_q == TIMER_MAX) begin
      stuck_d = stuck_q;
    end else begin
      stuck_d = stuck_q + TW'(1);
    end

    hang_d       = hang_q;
    hang_cycle_d = hang_cycle_q;
    if (!hang_q && stuck_q == TIMER_MAX) begin
      hang_d       = 1'b1;
      hang_cycle_d = cycle_cnt_q;
    end

    // Interval counter tracks cycle_cnt modulo REPORT_INTERVAL, realigned when cycle_cnt wraps.
    if (&cycle_cnt_q) begin
      intv_d = '0;
    end else if (intv_q == INTV_LAST) begin
      intv_d = '0;
    end else begin
      intv_d = intv_q + IW'(1);
    end

    is_report      = (intv_q == '0) && (cycle_cnt_q != 64'd0);
    report_valid_d = is_report;
    report_cycle_d = report_cycle_q;
    report_instr_d = report_instr_q;
    report_win_d   = report_win_q;
    if (is_report) begin
      report_cycle_d = cycle_cnt_q;
      report_instr_d = instr_cnt_q;
      report_win_d   = instr_cnt_q - report_instr_q;
    end

    perr_d = perr_q | (retire & gap);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt_q    <= '0;
      instr_cnt_q    <= '0;
      stuck_q        <= '0;
      intv_q         <= '0;
      report_valid_q <= 1'b0;
      report_cycle_q <= '0;
      report_instr_q <= '0;
      report_win_q   <= '0;
      hang_q         <= 1'b0;
      hang_cycle_q   <= '0;
      perr_q         <= 1'b0;
    end else begin
      cycle_cnt_q    <= cycle_cnt_d;
      instr_cnt_q    <= instr_cnt_d;
      stuck_q        <= stuck_d;
      intv_q         <= intv_d;
      report_valid_q <= report_valid_d;
      report_cycle_q <= report_cycle_d;
      report_instr_q <= report_instr_d;
      report_win_q   <= report_win_d;
      hang_q         <= hang_d;
      hang_cycle_q   <= hang_cycle_d;
      perr_q         <= perr_d;
    end
  end

  assign instr_cnt           = instr_cnt_q;
  assign cycle_cnt           = cycle_cnt_q;
  assign report_valid        = report_valid_q;
  assign report_cycle        = report_cycle_q;
  assign report_instr        = report_instr_q;
  assign report_window_instr = report_win_q;
  assign hang                = hang_q;
  assign hang_cycle          = hang_cycle_q;
  assign protocol_err        = perr_q;

endmodule

// File: tb/tb_commit_monitor.sv
// tb/tb_commit_monitor.sv - self-checking bench for commit_monitor
// Cycle-level reference model compared every cycle, plus hand-computed milestone values.
module tb_commit_monitor;
  localparam int W  = 6;
  localparam int SL = 5000;
  localparam int RI = 10000;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  commit_valid = '0;
  logic          commit_is_walk = 1'b0;
  logic [63:0]   instr_cnt, cycle_cnt, report_cycle, report_instr, report_window_instr, hang_cycle;
  logic          report_valid, hang, protocol_err;

  commit_monitor #(.COMMIT_WIDTH(W), .STUCK_LIMIT(SL), .REPORT_INTERVAL(RI)) dut (
    .clock(clock), .reset(reset), .commit_valid(commit_valid), .commit_is_walk(commit_is_walk),
    .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt), .report_valid(report_valid),
    .report_cycle(report_cycle), .report_instr(report_instr),
    .report_window_instr(report_window_instr), .hang(hang), .hang_cycle(hang_cycle),
    .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected outputs for the cycle that follows each rising edge.
  longint      m_t = 0;
  longint      m_last_clear = -1;
  logic [63:0] m_instr = 0;
  logic        m_hang = 0;
  logic [63:0] m_hang_cycle = 0;
  logic        m_perr = 0;
  logic        m_rv = 0;
  logic [63:0] m_rc = 0, m_ri = 0, m_rw = 0;
  bit          chk_en = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_t = 0; m_last_clear = -1; m_instr = 0; m_hang = 0; m_hang_cycle = 0;
      m_perr = 0; m_rv = 0; m_rc = 0; m_ri = 0; m_rw = 0;
    end else begin
      int v;
      v = int'(commit_valid);
      if (!m_hang && (m_t - m_last_clear - 1) > SL) begin
        m_hang = 1;
        m_hang_cycle = 64'(m_t);
      end
      m_rv = (m_t != 0) && (m_t % RI == 0);
      if (m_rv) begin
        m_rc = 64'(m_t);
        m_rw = m_instr - m_ri;
        m_ri = m_instr;
      end
      if (!commit_is_walk) begin
        if (commit_valid[0]) m_last_clear = m_t;
        if ((v & (v + 1)) != 0) m_perr = 1;
        m_instr = m_instr + 64'($countones(commit_valid));
      end
      m_t = m_t + 1;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("cycle_cnt", cycle_cnt, 64'(m_t));
      chk("instr_cnt", instr_cnt, m_instr);
      chk("hang", {63'd0, hang}, {63'd0, m_hang});
      chk("hang_cycle", hang_cycle, m_hang_cycle);
      chk("protocol_err", {63'd0, protocol_err}, {63'd0, m_perr});
      chk("report_valid", {63'd0, report_valid}, {63'd0, m_rv});
      chk("report_cycle", report_cycle, m_rc);
      chk("report_instr", report_instr, m_ri);
      chk("report_window", report_window_instr, m_rw);
    end
  end

  int cur;

  task automatic do_reset(input int k);
    reset = 1'b1;
    commit_valid = '0;
    commit_is_walk = 1'b0;
    repeat (k) begin
      @(posedge clock);
      @(negedge clock);
    end
    chk_en = 1;
    reset = 1'b0;
    cur = 0;
  endtask

  task automatic step(input logic [W-1:0] cv, input logic walk, input int k);
    repeat (k) begin
      commit_valid = cv;
      commit_is_walk = walk;
      @(posedge clock);
      @(negedge clock);
      cur++;
    end
  endtask

  initial begin
    // Single-slot retirement every cycle.
    do_reset(3);
    step(6'b000001, 1'b0, 100);
    chk("a_instr_100", instr_cnt, 64'd100);
    chk("a_cycle_100", cycle_cnt, 64'd100);
    step(6'b000001, 1'b0, 100);
    chk("a_no_hang", {63'd0, hang}, 64'd0);

    // No commits at all: hang timing, stickiness, then a mid-run reset.
    do_reset(2);
    step(6'b000000, 1'b0, 5001);
    chk("b_hang_5001", {63'd0, hang}, 64'd0);
    step(6'b000000, 1'b0, 1);
    chk("b_hang_5002", {63'd0, hang}, 64'd1);
    chk("b_hang_cycle", hang_cycle, 64'd5001);
    step(6'b000001, 1'b0, 20);
    chk("b_hang_sticky", {63'd0, hang}, 64'd1);
    chk("b_hang_cycle_sticky", hang_cycle, 64'd5001);
    step(6'b000000, 1'b0, 7000 - cur);
    reset = 1'b1;
    commit_valid = 6'b111111;
    @(posedge clock);
    @(negedge clock);
    chk("b_rst_cycle", cycle_cnt, 64'd0);
    chk("b_rst_instr", instr_cnt, 64'd0);
    chk("b_rst_hang", {63'd0, hang}, 64'd0);
    chk("b_rst_hang_cycle", hang_cycle, 64'd0);
    chk("b_rst_report", report_instr, 64'd0);
    reset = 1'b0;
    cur = 0;
    chk("b_restart_0", cycle_cnt, 64'd0);
    step(6'b000001, 1'b0, 3);
    chk("b_restart_3", cycle_cnt, 64'd3);
    chk("b_restart_instr", instr_cnt, 64'd3);

    // Full-width commits: two progress reports.
    do_reset(2);
    step(6'b111111, 1'b0, 10000);
    chk("c_no_report_10000", {63'd0, report_valid}, 64'd0);
    step(6'b111111, 1'b0, 1);
    chk("c_report_10001", {63'd0, report_valid}, 64'd1);
    chk("c_report_cycle", report_cycle, 64'd10000);
    chk("c_report_instr", report_instr, 64'd60000);
    chk("c_report_win", report_window_instr, 64'd60000);
    step(6'b111111, 1'b0, 1);
    chk("c_strobe_len", {63'd0, report_valid}, 64'd0);
    chk("c_report_held", report_instr, 64'd60000);
    step(6'b111111, 1'b0, 20001 - cur);
    chk("c_report_20001", {63'd0, report_valid}, 64'd1);
    chk("c_report2_cycle", report_cycle, 64'd20000);
    chk("c_report2_instr", report_instr, 64'd120000);
    chk("c_report2_win", report_window_instr, 64'd60000);

    // Walk cycles neither retire nor clear the stuck timer; then a gapped mask.
    do_reset(2);
    step(6'b000001, 1'b0, 10);
    step(6'b111111, 1'b1, 100);
    chk("d_walk_instr", instr_cnt, 64'd10);
    step(6'b000000, 1'b0, 5011 - cur);
    chk("d_hang_5011", {63'd0, hang}, 64'd0);
    step(6'b000000, 1'b0, 1);
    chk("d_hang_5012", {63'd0, hang}, 64'd1);
    chk("d_hang_cycle", hang_cycle, 64'd5011);
    chk("d_perr_before", {63'd0, protocol_err}, 64'd0);
    step(6'b000010, 1'b0, 1);
    chk("d_perr", {63'd0, protocol_err}, 64'd1);
    chk("d_perr_instr", instr_cnt, 64'd11);
    step(6'b000000, 1'b0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
